// File: rtl/prng_lfsr_gen.sv
// Fibonacci-style LFSR word generator with valid/ready output handshake and accepted-word counter.
// Optional all-zero lockup recovery is compiled in with `define PRNG_LOCKUP_DETECT_EN.
module prng_lfsr_gen #(
  parameter int              WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(8'hB8),
  parameter int              STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_syn,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             en,
  output logic [WIDTH-1:0] rnd_out,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [CNT_W-1:0] word_cnt,
  output logic             lockup
);

  logic [WIDTH-1:0]            state;
  logic [STEPS:0][WIDTH-1:0]   shift_chain;
  logic [WIDTH-1:0]            adv_state;
  logic [WIDTH-1:0]            seed_eff;
  logic                        advance;
  logic                        accept;

  // STEPS single shifts unrolled into one combinational chain
  assign shift_chain[0] = state;
  for (genvar g = 0; g < STEPS; g++) begin : g_shift
    assign shift_chain[g+1] = {shift_chain[g][WIDTH-2:0], ^(shift_chain[g] & TAPS)};
  end

  // A held word blocks generation until it is consumed
  assign advance = en & ~set_syn & (~rnd_valid | rnd_ready);
  assign accept  = rnd_valid & rnd_ready;

`ifdef PRNG_LOCKUP_DETECT_EN
  logic seed_zero;
  logic adv_zero;
  logic lockup_q;

  assign seed_zero = (seed_in == '0);
  assign adv_zero  = (shift_chain[STEPS] == '0);
  assign seed_eff  = seed_zero ? DEFAULT_SEED : seed_in;
  assign adv_state = adv_zero  ? DEFAULT_SEED : shift_chain[STEPS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lockup_q <= 1'b0;
    else     lockup_q <= set_syn ? seed_zero : (advance & adv_zero);
  end
  assign lockup = lockup_q;
`else
  assign seed_eff  = seed_in;
  assign adv_state = shift_chain[STEPS];
  assign lockup    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DEFAULT_SEED;
      rnd_out   <= '0;
      rnd_valid <= 1'b0;
      word_cnt  <= '0;
    end else if (set_syn) begin
      // reseed discards any presented word; rnd_out keeps its last value
      state     <= seed_eff;
      rnd_valid <= 1'b0;
      word_cnt  <= '0;
    end else begin
      if (accept) word_cnt <= word_cnt + CNT_W'(1);
      if (advance) begin
        state     <= adv_state;
        rnd_out   <= adv_state;
        rnd_valid <= 1'b1;
      end else if (accept) begin
        rnd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/prng_lfsr_gen.md
PRNG_LFSR_GEN -- requirements
Module: prng_lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 8, LFSR/output width; legal range 4..32.
REQ-002 Parameter TAPS, default 8'hB8, feedback mask (WIDTH bits); bit i set = state[i] feeds the XOR.
REQ-003 Parameter STEPS, default 1, LFSR shifts per advance; legal range 1..WIDTH.
REQ-004 Parameter DEFAULT_SEED, default 1, non-zero state loaded at reset (WIDTH bits).
REQ-005 Parameter CNT_W, default 16, width of the delivered-word counter.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 set_syn  input  1  synchronous seed load, active-high.
REQ-009 seed_in  input  WIDTH  seed value sampled when set_syn=1.
REQ-010 en  input  1  generation enable.
REQ-011 rnd_out  output  WIDTH  registered random word.
REQ-012 rnd_valid  output  1  rnd_out holds an unconsumed word.
REQ-013 rnd_ready  input  1  consumer accepts rnd_out this cycle.
REQ-014 word_cnt  output  CNT_W  count of words accepted (rnd_valid & rnd_ready).
REQ-015 lockup  output  1  one-cycle pulse, all-zero seed replaced (macro builds only; tied 0 otherwise).

Function
REQ-016 One shift SHALL be: fb = XOR-reduce(state & TAPS); state = {state[WIDTH-2:0], fb}.
REQ-017 An advance SHALL apply STEPS shifts combinationally in one cycle.
REQ-018 Advance condition: en=1 and set_syn=0 and (rnd_valid=0 or rnd_ready=1).
REQ-019 On advance, state and rnd_out SHALL both take the post-advance state and rnd_valid SHALL be 1 on the next cycle (latency 1 clock from qualifying edge).
REQ-020 When rnd_valid=1 and rnd_ready=0, rnd_out and state SHALL hold unchanged regardless of en.
REQ-021 When rnd_valid=1, rnd_ready=1, en=0: rnd_valid SHALL clear next cycle, state held.
REQ-022 Accept (rnd_valid & rnd_ready) SHALL increment word_cnt by 1, wrapping 2^CNT_W-1 -> 0.
REQ-023 set_syn=1 SHALL have priority over advance: state <= seed_in, rnd_valid <= 0, word_cnt <= 0, rnd_out held; a word presented that cycle is discarded, not counted.
REQ-024 An all-zero state without the macro SHALL persist (rnd_out stays 0 while advancing).
REQ-025 With WIDTH=8, TAPS=8'hB8, STEPS=1 the sequence SHALL be maximal length (period 255).

Reset
REQ-026 rst=1 SHALL immediately set state=DEFAULT_SEED, rnd_out=0, rnd_valid=0, word_cnt=0, lockup=0.
REQ-027 rst asserted mid-stream SHALL abort the pending word; first word after release is the first advance from DEFAULT_SEED.

Configuration
REQ-028 Macro PRNG_LOCKUP_DETECT_EN: when defined, set_syn with seed_in=0 SHALL load DEFAULT_SEED instead and pulse lockup for one cycle; any state reaching all-zero SHALL be replaced by DEFAULT_SEED on the same edge with lockup pulse.
REQ-029 Without PRNG_LOCKUP_DETECT_EN: no detection logic, lockup tied 0, REQ-024 applies.

Verification (WIDTH=8, TAPS=8'hB8, STEPS=1, DEFAULT_SEED=1 unless stated)
REQ-030 Reset release, en=1, rnd_ready=1 -> rnd_out 8'h02, 8'h04, 8'h08, 8'h11, 8'h23 on successive cycles; rnd_valid=1 from first advance.
REQ-031 Run 255 accepts from seed 8'h01 -> rnd_out returns to 8'h01 at word 255, no repeat earlier, word_cnt=255.
REQ-032 rnd_ready=0 for 5 cycles while rnd_valid=1 -> rnd_out frozen, word_cnt unchanged; raise rnd_ready -> next value follows with no skip.
REQ-033 set_syn=1, seed_in=8'hA5 while rnd_valid=1, rnd_ready=1 -> word_cnt=0, rnd_valid=0 next cycle, following word = one-shift successor of 8'hA5 (8'h4A).
REQ-034 set_syn with seed_in=0: macro defined -> lockup pulse 1 cycle, next word 8'h02; macro undefined -> lockup=0, rnd_out stays 8'h00.
REQ-035 STEPS=8, seed 8'h01 -> each word equals eight single-shift steps of the STEPS=1 model; rst asserted mid-run -> outputs reset asynchronously before next edge.
